// File: rtl/data_mem_lat_pkg.sv
// Shared definitions for the latency-configurable data memory:
// FSM encoding, countdown width and byte-lane helper.
package dmem_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int CNT_W = 4;

  function automatic int laneCount(input int dataW);
    return dataW / 8;
  endfunction

endpackage

// File: rtl/data_mem_lat_if.sv
// Request/acknowledge bus between a load/store unit (master) and the
// latency-configurable data memory (slave).
interface data_mem_lat_if
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
);

  logic                           mrd;
  logic                           mwr;
  logic [31:0]                    adr;
  logic [DATA_W-1:0]              d_in;
  logic [laneCount(DATA_W)-1:0]   data_out_mask;
  logic [DATA_W-1:0]              d_out;
  logic                           busy;
  logic                           ack;
  logic                           err;

  modport master (
    output mrd, mwr, adr, d_in, data_out_mask,
    input  d_out, busy, ack, err
  );

  modport slave (
    input  mrd, mwr, adr, d_in, data_out_mask,
    output d_out, busy, ack, err
  );

endinterface

// File: rtl/data_mem_lat_array.sv
// DEPTH x DATA_W single-port storage with per-byte write enables and a
// registered read port whose value holds until the next read.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_rdEn,
  input  logic [laneCount(DATA_W)-1:0] i_we,
  input  logic [AW-1:0]                i_addr,
  input  logic [DATA_W-1:0]            i_wdata,
  output logic [DATA_W-1:0]            o_rdata
);

  localparam int LANES = laneCount(DATA_W);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Storage is deliberately left out of reset; only enabled lanes change.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (i_we[i]) begin
        r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else if (i_rdEn) begin
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_mem_lat.sv
// Data memory with configurable access latency, req/ack handshake and
// range/conflict error reporting in front of a byte-lane storage array.
module data_mem_lat
  import dmem_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic           clk,
  input  logic           rst,
  data_mem_lat_if.slave  bus
);

  localparam int LANES     = laneCount(DATA_W);
  localparam int LANE_BITS = (LANES > 1) ? $clog2(LANES) : 0;
  localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_t             r_state;
  state_t             w_nextState;
  logic [CNT_W-1:0]   r_cnt;
  logic [31:0]        r_adr;
  logic [DATA_W-1:0]  r_din;
  logic [LANES-1:0]   r_mask;
  logic               r_rd;
  logic               r_wr;
  logic               r_ack;
  logic               r_err;

  logic               w_accept;
  logic               w_fire;
  logic               w_inRange;
  logic               w_conflict;
  logic [31:0]        w_off;
  logic [31:0]        w_idx;
  logic               w_rdEn;
  logic [LANES-1:0]   w_we;
  logic [DATA_W-1:0]  w_rdata;

  // Unsigned offset: addresses below the base wrap to huge indices.
  assign w_off      = r_adr - BASE_ADDR;
  assign w_idx      = w_off >> LANE_BITS;
  assign w_inRange  = (w_idx < 32'(DEPTH));
  assign w_conflict = r_rd && r_wr;
  assign w_accept   = (r_state == IDLE) && (bus.mrd || bus.mwr);
  assign w_fire     = (r_state == WAIT) && (r_cnt == '0) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_ack   <= w_fire;
      r_err   <= w_fire && (!w_inRange || w_conflict);
      if (w_accept) begin
        r_cnt <= CNT_W'(LATENCY - 1);
      end else if ((r_state == WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      r_adr  <= bus.adr;
      r_din  <= bus.d_in;
      r_mask <= bus.data_out_mask;
      r_rd   <= bus.mrd;
      r_wr   <= bus.mwr;
    end
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (bus.mrd || bus.mwr) w_nextState = WAIT;
      WAIT:    if (r_cnt == '0)        w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The access is issued to the array on the same edge that raises ack.
  always_comb begin
    w_rdEn        = w_fire && w_inRange && r_rd && !r_wr;
    w_we          = '0;
    if (w_fire && w_inRange && r_wr && !r_rd) begin
      w_we = r_mask;
    end
    bus.busy  = (r_state == WAIT);
    bus.ack   = r_ack;
    bus.err   = r_err;
    bus.d_out = w_rdata;
  end

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_rdEn  (w_rdEn),
    .i_we    (w_we),
    .i_addr  (w_idx[AW-1:0]),
    .i_wdata (r_din),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_data_mem_lat.sv
// Scoreboard bench for data_mem_lat: directed requests push expected
// responses; a negedge monitor pops and compares on every ack.
module tb_data_mem_lat;

  localparam int          DATA_W  = 32;
  localparam int          DEPTH   = 64;
  localparam int          LATENCY = 2;
  localparam logic [31:0] BASE    = 32'h0000_0100;

  typedef struct {
    logic        err;
    logic [31:0] data;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests  = 0;
  int   failed = 0;
  exp_t q[$];

  data_mem_lat_if #(.DATA_W(DATA_W)) bus ();

  data_mem_lat #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY),
    .BASE_ADDR (BASE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic failTest(input string name);
    tests++;
    failed++;
    $display("[TB] FAIL %s: got event expected none", name);
  endtask

  // Called at a negedge; drives one request and waits for its ack.
  task automatic applyStimulus(input bit rd, input bit wr, input logic [31:0] a,
                               input logic [31:0] d, input logic [3:0] m,
                               input bit expErr, input logic [31:0] expData,
                               input string name, input bit intrude = 1'b0);
    exp_t e;
    int   lat;
    e.err  = expErr;
    e.data = expData;
    e.name = name;
    q.push_back(e);
    bus.mrd = rd;
    bus.mwr = wr;
    bus.adr = a;
    bus.d_in = d;
    bus.data_out_mask = m;
    @(posedge clk);
    #1;
    bus.mrd = 1'b0;
    bus.mwr = 1'b0;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) begin
        checkOutput({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
        if (intrude) begin
          bus.mwr = 1'b1;
          bus.adr = 32'h0000_0110;
          bus.d_in = 32'h0000_0000;
          bus.data_out_mask = 4'hF;
        end
      end
      if (bus.ack) begin
        lat = k;
        bus.mwr = 1'b0;
        break;
      end
    end
    checkOutput({name, "_lat"}, 32'(lat), 32'(LATENCY + 1));
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.ack) begin
      if (q.size() == 0) begin
        failTest("unexpected_ack");
      end else begin
        e = q.pop_front();
        checkOutput({e.name, "_err"}, {31'd0, bus.err}, {31'd0, e.err});
        checkOutput({e.name, "_dout"}, bus.d_out, e.data);
      end
    end else if (!rst) begin
      checkOutput("err_idle", {31'd0, bus.err}, 32'd0);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got no finish expected finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bus.mrd = 1'b0;
    bus.mwr = 1'b0;
    bus.adr = '0;
    bus.d_in = '0;
    bus.data_out_mask = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_ack",  {31'd0, bus.ack},  32'd0);
    checkOutput("rst_err",  {31'd0, bus.err},  32'd0);
    checkOutput("rst_dout", bus.d_out, 32'd0);
    rst = 1'b0;

    applyStimulus(0, 1, 32'h104, 32'hDEADBEEF, 4'hF, 0, 32'h00000000, "w104");
    applyStimulus(1, 0, 32'h104, 32'h0,        4'h0, 0, 32'hDEADBEEF, "r104");
    applyStimulus(0, 1, 32'h108, 32'h11223344, 4'hF, 0, 32'hDEADBEEF, "w108pre");
    applyStimulus(0, 1, 32'h108, 32'hAABBCCDD, 4'h5, 0, 32'hDEADBEEF, "w108mask");
    applyStimulus(1, 0, 32'h108, 32'h0,        4'h0, 0, 32'h11BB33DD, "r108");
    applyStimulus(0, 1, 32'h100, 32'h01020304, 4'hF, 0, 32'h11BB33DD, "w100");
    applyStimulus(1, 0, 32'h200, 32'h0,        4'h0, 1, 32'h11BB33DD, "r200oor");
    applyStimulus(1, 0, 32'h0FC, 32'h0,        4'h0, 1, 32'h11BB33DD, "r0FCbelow");
    applyStimulus(0, 1, 32'h200, 32'hFFFFFFFF, 4'hF, 1, 32'h11BB33DD, "w200oor");
    applyStimulus(1, 0, 32'h100, 32'h0,        4'h0, 0, 32'h01020304, "r100");
    applyStimulus(1, 0, 32'h104, 32'h0,        4'h0, 0, 32'hDEADBEEF, "r104b");
    applyStimulus(0, 1, 32'h110, 32'h55667788, 4'hF, 0, 32'hDEADBEEF, "w110");
    applyStimulus(1, 0, 32'h104, 32'h0,        4'h0, 0, 32'hDEADBEEF, "r104busy", 1'b1);
    applyStimulus(1, 0, 32'h110, 32'h0,        4'h0, 0, 32'h55667788, "r110");
    applyStimulus(1, 1, 32'h104, 32'h0,        4'hF, 1, 32'h55667788, "rw104");
    applyStimulus(1, 0, 32'h104, 32'h0,        4'h0, 0, 32'hDEADBEEF, "r104c");
    applyStimulus(0, 1, 32'h10C, 32'h0BADF00D, 4'hF, 0, 32'hDEADBEEF, "w10Cpre");

    // Write accepted, then reset on the following edge aborts it.
    bus.mwr = 1'b1;
    bus.adr = 32'h10C;
    bus.d_in = 32'hFFFFFFFF;
    bus.data_out_mask = 4'hF;
    @(posedge clk);
    #1;
    bus.mwr = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_ack",  {31'd0, bus.ack},  32'd0);
    checkOutput("midrst_dout", bus.d_out, 32'd0);
    rst = 1'b0;
    repeat (6) @(negedge clk);

    applyStimulus(1, 0, 32'h10C, 32'h0, 4'h0, 0, 32'h0BADF00D, "r10C");
    repeat (3) @(negedge clk);
    checkOutput("queue_empty", 32'(q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
